// File: rtl/adc_word_packer.sv
// Packs pairs of 16-bit ADC result frames into 32-bit FIFO words, flushing a
// lone half-word with PAD when capture stops, and tracks drops and interrupts.
module adc_word_packer #(
  parameter int unsigned THRESH = 512,
  parameter logic [15:0] PAD    = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] din,
  input  logic        din_valid,
  input  logic        fifo_full,
  input  logic        clr_stat,
  output logic [31:0] fifo_din,
  output logic        fifo_wr_en,
  output logic        hostinterrupt,
  output logic        overflow,
  output logic [15:0] drop_count,
  output logic        busy
);

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } state_t;

  state_t      r_state;
  logic [15:0] r_held;
  logic [15:0] r_int_cnt;

  logic        w_accept;
  logic        w_word_done;
  logic        w_write;
  logic        w_drop;
  logic [31:0] w_word;
  logic [16:0] w_cnt_inc;
  logic [16:0] w_thresh;

  // Handshake: din is taken only on din_valid=1 with en=1; en=0 wins over a
  // coincident strobe, so a held half-word is flushed instead of completed.
  assign w_accept    = din_valid & en;
  assign w_word_done = (r_state == HALF) & (din_valid | ~en);
  assign w_word      = en ? {din, r_held} : {PAD, r_held};
  assign w_write     = w_word_done & ~fifo_full;
  assign w_drop      = w_word_done & fifo_full;
  assign w_cnt_inc   = {1'b0, r_int_cnt} + 17'd1;
  assign w_thresh    = 17'(THRESH);

  assign busy = (r_state == HALF);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= EMPTY;
      r_held        <= 16'h0000;
      r_int_cnt     <= 16'h0000;
      fifo_din      <= 32'h0000_0000;
      fifo_wr_en    <= 1'b0;
      hostinterrupt <= 1'b0;
      overflow      <= 1'b0;
      drop_count    <= 16'h0000;
    end else begin
      fifo_wr_en <= w_write;
      if (w_write) begin
        fifo_din <= w_word;
      end

      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_held  <= din;
            r_state <= HALF;
          end
        end
        HALF: begin
          if (w_word_done) begin
            r_state <= EMPTY;
          end
        end
        default: r_state <= EMPTY;
      endcase

      // A drop in the same cycle as clr_stat restarts the count at one.
      if (w_drop) begin
        overflow <= 1'b1;
        if (clr_stat) begin
          drop_count <= 16'h0001;
        end else if (drop_count != 16'hFFFF) begin
          drop_count <= drop_count + 16'h0001;
        end
      end else if (clr_stat) begin
        overflow   <= 1'b0;
        drop_count <= 16'h0000;
      end

      hostinterrupt <= 1'b0;
      if (fifo_wr_en) begin
        if (w_cnt_inc == w_thresh) begin
          r_int_cnt     <= 16'h0000;
          hostinterrupt <= 1'b1;
        end else begin
          r_int_cnt <= w_cnt_inc[15:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_word_packer.sv
// Directed bench for adc_word_packer with THRESH=4: pairing, flush, drops,
// stat clearing, interrupt cadence and asynchronous reset.
module tb_adc_word_packer;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] din;
  logic        din_valid;
  logic        fifo_full;
  logic        clr_stat;
  logic [31:0] fifo_din;
  logic        fifo_wr_en;
  logic        hostinterrupt;
  logic        overflow;
  logic [15:0] drop_count;
  logic        busy;

  int nvec  = 0;
  int nfail = 0;
  int n_int = 0;
  int n_wr  = 0;

  adc_word_packer #(.THRESH(4), .PAD(16'hFFFF)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .din(din),
    .din_valid(din_valid),
    .fifo_full(fifo_full),
    .clr_stat(clr_stat),
    .fifo_din(fifo_din),
    .fifo_wr_en(fifo_wr_en),
    .hostinterrupt(hostinterrupt),
    .overflow(overflow),
    .drop_count(drop_count),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    din       = d;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; din = 16'h0000; din_valid = 1'b0;
    fifo_full = 1'b0; clr_stat = 1'b0;
    repeat (3) tick();
    chk("rst_fifo_din", fifo_din, 32'h0);
    chk("rst_wr_en", {31'b0, fifo_wr_en}, 32'h0);
    chk("rst_hostint", {31'b0, hostinterrupt}, 32'h0);
    chk("rst_overflow", {31'b0, overflow}, 32'h0);
    chk("rst_drop_count", {16'b0, drop_count}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    rst = 1'b1;
    tick();

    // Basic pairing
    en = 1'b1;
    send(16'h1234);
    chk("pair_busy_half", {31'b0, busy}, 32'h1);
    chk("pair_no_wr_first", {31'b0, fifo_wr_en}, 32'h0);
    send(16'hABCD);
    chk("pair_wr_en", {31'b0, fifo_wr_en}, 32'h1);
    chk("pair_data", fifo_din, 32'hABCD1234);
    chk("pair_busy_empty", {31'b0, busy}, 32'h0);
    tick();
    chk("pair_wr_one_cycle", {31'b0, fifo_wr_en}, 32'h0);
    chk("pair_data_hold", fifo_din, 32'hABCD1234);

    // Flush of a lone half-word on en low
    send(16'h0F0F);
    chk("flush_busy_half", {31'b0, busy}, 32'h1);
    en = 1'b0;
    tick();
    chk("flush_wr_en", {31'b0, fifo_wr_en}, 32'h1);
    chk("flush_data", fifo_din, 32'hFFFF0F0F);
    chk("flush_busy_empty", {31'b0, busy}, 32'h0);
    tick();
    tick();
    chk("flush_empty_no_wr", {31'b0, fifo_wr_en}, 32'h0);

    // Three dropped words, then clear
    en = 1'b1;
    fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send(16'h1000 + 16'(k));
      send(16'h2000 + 16'(k));
      chk("drop_no_wr", {31'b0, fifo_wr_en}, 32'h0);
    end
    chk("drop_overflow", {31'b0, overflow}, 32'h1);
    chk("drop_count3", {16'b0, drop_count}, 32'd3);
    chk("drop_data_hold", fifo_din, 32'hFFFF0F0F);
    chk("drop_busy_empty", {31'b0, busy}, 32'h0);
    fifo_full = 1'b0;
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    chk("clr_overflow", {31'b0, overflow}, 32'h0);
    chk("clr_drop_count", {16'b0, drop_count}, 32'h0);

    // Drop coinciding with clr_stat
    fifo_full = 1'b1;
    send(16'h3000);
    send(16'h3001);
    chk("pri_pre_count", {16'b0, drop_count}, 32'd1);
    send(16'h3002);
    din = 16'h3003; din_valid = 1'b1; clr_stat = 1'b1;
    tick();
    din_valid = 1'b0; clr_stat = 1'b0;
    chk("pri_overflow", {31'b0, overflow}, 32'h1);
    chk("pri_drop_count", {16'b0, drop_count}, 32'd1);
    fifo_full = 1'b0;
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    chk("pri_clr_count", {16'b0, drop_count}, 32'h0);

    // Strobe in the same cycle en falls
    send(16'h0001);
    din = 16'h5555; din_valid = 1'b1; en = 1'b0;
    tick();
    din_valid = 1'b0;
    chk("coinc_wr_en", {31'b0, fifo_wr_en}, 32'h1);
    chk("coinc_data", fifo_din, 32'hFFFF0001);
    chk("coinc_busy", {31'b0, busy}, 32'h0);
    tick();
    chk("coinc_no_second_wr", {31'b0, fifo_wr_en}, 32'h0);
    chk("coinc_sample_ignored", {31'b0, busy}, 32'h0);

    // Asynchronous reset while holding a half-word
    en = 1'b1;
    send(16'hDEAD);
    chk("arst_pre_busy", {31'b0, busy}, 32'h1);
    rst = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'h0);
    chk("arst_fifo_din", fifo_din, 32'h0);
    chk("arst_wr_en", {31'b0, fifo_wr_en}, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    en = 1'b0;
    tick();
    chk("arst_no_stale_flush", {31'b0, fifo_wr_en}, 32'h0);
    en = 1'b1;
    send(16'h1111);
    send(16'h2222);
    chk("arst_pack_wr", {31'b0, fifo_wr_en}, 32'h1);
    chk("arst_pack_data", fifo_din, 32'h22221111);
    tick();

    // Interrupt cadence from a clean counter
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    for (int w = 1; w <= 8; w++) begin
      send(16'h4000 + 16'(2 * w));
      chk("int_pre_hostint", {31'b0, hostinterrupt}, 32'h0);
      send(16'h5000 + 16'(2 * w + 1));
      chk("int_wr_en", {31'b0, fifo_wr_en}, 32'h1);
      chk("int_data", fifo_din, {16'h5000 + 16'(2 * w + 1), 16'h4000 + 16'(2 * w)});
      if (fifo_wr_en === 1'b1) n_wr++;
      tick();
      chk("int_hostint", {31'b0, hostinterrupt}, (w % 4 == 0) ? 32'h1 : 32'h0);
      if (hostinterrupt === 1'b1) n_int++;
    end
    tick();
    chk("int_hostint_idle", {31'b0, hostinterrupt}, 32'h0);
    chk("int_write_total", n_wr, 32'd8);
    chk("int_pulse_total", n_int, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
